// File: rtl/tracker_pkg.sv
// Shared constants and types for the pan/tilt axis tracker controller.
package tracker_pkg;

  localparam logic [1:0] DIR_STOP = 2'b00;
  localparam logic [1:0] DIR_DEC  = 2'b01;
  localparam logic [1:0] DIR_INC  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AUTO = 2'd1,
    ST_MOVE = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // (a - b) mod m, valid for a < m and b < m.
  function automatic logic [31:0] mod_sub(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] m);
    logic [31:0] r;
    if (a >= b) begin
      r = a - b;
    end else begin
      r = a + m - b;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_tracker_ctrl_wrap_dist.sv
// Shortest-way-around-the-circle direction for one axis, plus an in-band flag.
module wrap_dist
  import tracker_pkg::*;
#(
  parameter int W         = 16,
  parameter int FULL_TURN = 360,
  parameter int DEADBAND  = 4
) (
  input  logic [W-1:0] target_i,
  input  logic [W-1:0] actual_i,
  output logic         in_band_o,
  output logic [1:0]   dir_o
);

  localparam logic [W-1:0] FT_W   = W'(FULL_TURN);
  localparam logic [31:0]  DB_32  = 32'(DEADBAND);
  localparam logic [31:0]  HI_32  = 32'(FULL_TURN - DEADBAND);
  localparam logic [31:0]  HALF32 = 32'(FULL_TURN / 2);

  logic [W-1:0] act_red_s;
  logic [31:0]  fwd_s;

  // Forward distance from reduced actual to target, then band/direction decision.
  always_comb begin
    act_red_s = actual_i % FT_W;
    fwd_s     = mod_sub(32'(target_i), 32'(act_red_s), 32'(FULL_TURN));
    in_band_o = (fwd_s <= DB_32) || (fwd_s >= HI_32);
    if (in_band_o) begin
      dir_o = DIR_STOP;
    end else if (fwd_s <= HALF32) begin
      dir_o = DIR_INC;
    end else begin
      dir_o = DIR_DEC;
    end
  end

endmodule

// File: rtl/axis_tracker_ctrl.sv
// Multi-axis direction controller: automatic sensor balancing or sequential
// manual moves to angular setpoints, with registered 2-bit codes per axis.
module axis_tracker_ctrl
  import tracker_pkg::*;
#(
  parameter int W          = 16,
  parameter int N_AXES     = 2,
  parameter int DEADBAND   = 4,
  parameter int FULL_TURN  = 360,
  parameter int SETTLE_CYC = 1000
) (
  input  logic                rst_i,
  input  logic                clk_i,
  input  logic                s_i,
  input  logic                start_i,
  input  logic [N_AXES*W-1:0] sens_a_i,
  input  logic [N_AXES*W-1:0] sens_b_i,
  input  logic [N_AXES*W-1:0] angle_d_i,
  input  logic [N_AXES*W-1:0] angle_act_i,
  output logic [2*N_AXES-1:0] dir_out_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                range_err_o
);

  localparam int AW = (N_AXES > 1) ? $clog2(N_AXES) : 1;
  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYC - 1);
  localparam logic [AW-1:0] AX_LAST  = AW'(N_AXES - 1);
  localparam logic [W:0]    DB_W     = (W+1)'(DEADBAND);
  localparam logic [W-1:0]  FT_W     = W'(FULL_TURN);

  state_e              state_q;
  logic [AW-1:0]       axis_q;
  logic [2*N_AXES-1:0] dir_q;
  logic                busy_q;
  logic                done_q;
  logic                range_err_q;
  logic [W-1:0]        setpt_q [N_AXES];
  logic [CW-1:0]       cnt_q   [N_AXES];

  logic [N_AXES-1:0]   band_s;
  logic [2*N_AXES-1:0] wdir_s;
  logic [2*N_AXES-1:0] auto_dir_s;
  logic [2*N_AXES-1:0] move_dir_s;
  logic                act_band_s;
  logic [CW-1:0]       act_cnt_s;
  logic                range_bad_s;
  logic [W:0]          a_w_s;
  logic [W:0]          b_w_s;
  logic [1:0]          raw_s;
  logic [1:0]          prev_s;

  for (genvar k = 0; k < N_AXES; k++) begin : g_axis
    wrap_dist #(
      .W        (W),
      .FULL_TURN(FULL_TURN),
      .DEADBAND (DEADBAND)
    ) u_wrap (
      .target_i (setpt_q[k]),
      .actual_i (angle_act_i[k*W +: W]),
      .in_band_o(band_s[k]),
      .dir_o    (wdir_s[2*k +: 2])
    );
  end

  // Automatic comparators with reversal guard, active-axis selection, setpoint check.
  always_comb begin
    auto_dir_s  = '0;
    move_dir_s  = '0;
    act_band_s  = 1'b0;
    act_cnt_s   = '0;
    range_bad_s = 1'b0;
    a_w_s       = '0;
    b_w_s       = '0;
    raw_s       = DIR_STOP;
    prev_s      = DIR_STOP;
    for (int k = 0; k < N_AXES; k++) begin
      a_w_s = {1'b0, sens_a_i[k*W +: W]};
      b_w_s = {1'b0, sens_b_i[k*W +: W]};
      if ((a_w_s <= b_w_s + DB_W) && (b_w_s <= a_w_s + DB_W)) begin
        raw_s = DIR_STOP;
      end else if (a_w_s < b_w_s) begin
        raw_s = DIR_DEC;
      end else begin
        raw_s = DIR_INC;
      end
      prev_s = dir_q[2*k +: 2];
      // A direct DEC<->INC flip is held at STOP for one cycle.
      if (((raw_s == DIR_INC) && (prev_s == DIR_DEC)) ||
          ((raw_s == DIR_DEC) && (prev_s == DIR_INC))) begin
        auto_dir_s[2*k +: 2] = DIR_STOP;
      end else begin
        auto_dir_s[2*k +: 2] = raw_s;
      end
      move_dir_s[2*k +: 2] = (axis_q == AW'(k)) ? wdir_s[2*k +: 2] : DIR_STOP;
      act_band_s  = act_band_s | ((axis_q == AW'(k)) & band_s[k]);
      act_cnt_s   = act_cnt_s | ((axis_q == AW'(k)) ? cnt_q[k] : '0);
      range_bad_s = range_bad_s | (angle_d_i[k*W +: W] >= FT_W);
    end
  end

  // Control FSM with settle counters, setpoint latch and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      axis_q      <= '0;
      dir_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      for (int k = 0; k < N_AXES; k++) begin
        setpt_q[k] <= '0;
        cnt_q[k]   <= '0;
      end
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          dir_q <= '0;
          if (s_i) begin
            state_q <= ST_AUTO;
          end else if (start_i) begin
            for (int k = 0; k < N_AXES; k++) begin
              setpt_q[k] <= angle_d_i[k*W +: W];
              cnt_q[k]   <= '0;
            end
            if (range_bad_s) begin
              range_err_q <= 1'b1;
            end else begin
              range_err_q <= 1'b0;
              state_q     <= ST_MOVE;
              axis_q      <= '0;
              busy_q      <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_AUTO: begin
          if (!s_i) begin
            state_q <= ST_IDLE;
            dir_q   <= '0;
          end else begin
            dir_q <= auto_dir_s;
          end
        end
        ST_MOVE: begin
          if (s_i) begin
            state_q <= ST_AUTO;
            dir_q   <= '0;
            busy_q  <= 1'b0;
            axis_q  <= '0;
            for (int k = 0; k < N_AXES; k++) begin
              cnt_q[k] <= '0;
            end
          end else begin
            dir_q <= move_dir_s;
            if (!act_band_s) begin
              cnt_q[axis_q] <= '0;
            end else if (act_cnt_s == CNT_LAST) begin
              cnt_q[axis_q] <= '0;
              if (axis_q == AX_LAST) begin
                state_q <= ST_DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                axis_q  <= '0;
              end else begin
                axis_q <= axis_q + 1'b1;
              end
            end else begin
              cnt_q[axis_q] <= act_cnt_s + 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          dir_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          dir_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dir_out_o   = dir_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign range_err_o = range_err_q;

endmodule

// File: doc/axis_tracker_ctrl.md
# axis_tracker_ctrl

Parametrised multi-axis motor direction controller for the pan/tilt tracker. Each axis runs in one of two modes. In automatic mode it follows a sensor pair, balancing the two light readings. In manual mode it drives the axes one at a time to an angular setpoint, taking the shortest way around the circle. It sits between the sensor/angle-encoder front end and the motor drivers, and emits a registered 2-bit direction code per axis.

## Interface
Parameters:
- `W`, 16: width of sensor, angle and setpoint values.
- `N_AXES`, 2: number of axes. Axis 0 is vertical (teta), axis 1 is horizontal (fi).
- `DEADBAND`, 4: tolerance band, in LSBs, for both modes.
- `FULL_TURN`, 360: angle modulus. Must satisfy `FULL_TURN < 2**W`.
- `SETTLE_CYC`, 1000: consecutive in-band cycles required before a manual axis counts as arrived.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `s`, in, 1: mode select. 1 = automatic, 0 = manual.
- `start`, in, 1: one-cycle pulse that launches a manual move.
- `sens_a`, in, `N_AXES*W`: sensor A per axis, packed with axis 0 in the LSBs.
- `sens_b`, in, `N_AXES*W`: sensor B per axis.
- `angle_d`, in, `N_AXES*W`: manual setpoint per axis. Sampled on `start`.
- `angle_act`, in, `N_AXES*W`: current measured angle per axis.
- `dir_out`, out, `2*N_AXES`: direction code per axis. 00 = stop, 01 = decrement/left, 10 = increment/right. 11 is never driven.
- `busy`, out, 1: a manual move is in progress.
- `done`, out, 1: one-cycle pulse when a manual move completes.
- `range_err`, out, 1: sticky. Set when a sampled setpoint is `>= FULL_TURN`. Cleared by `rst` or by the next valid `start`.

## Operation
- All arithmetic is unsigned and widened to W+1 bits, so `b±DEADBAND` never wraps.
- **Automatic mode**, all axes evaluated in parallel every cycle:
  - `|a-b| <= DEADBAND` → 00.
  - `a < b` → 01.
  - `a > b` → 10.
  - Reversal guard: a change directly between 01 and 10 is replaced by one cycle of 00 first.
- **Manual mode**:
  - On `start` in IDLE, latch `angle_d` for every axis.
  - Any latched setpoint `>= FULL_TURN` sets `range_err` and returns to IDLE with no motion.
  - Axes are serviced sequentially, axis 0 first. Only the active axis may be non-zero; all others output 00.
- **Shortest path** per axis:
  - `fwd = (target - actual) mod FULL_TURN`.
  - In band when `fwd <= DEADBAND` or `fwd >= FULL_TURN-DEADBAND` → 00.
  - Otherwise `fwd <= FULL_TURN/2` → 10; else → 01. An exact half turn resolves to 10.
  - An `angle_act` value `>= FULL_TURN` is reduced mod `FULL_TURN` before use.
- **Settling**: the per-axis settle counter increments while in band and clears to 0 when the axis leaves the band. The axis is arrived when the counter reaches `SETTLE_CYC-1`; the FSM then advances to the next axis.
- **FSM states**: IDLE, AUTO, MOVE(k), DONE.
  - IDLE → AUTO when `s=1`.
  - IDLE → MOVE(0) on `start` with `s=0` and valid setpoints.
  - MOVE(k) → MOVE(k+1) when axis k is arrived.
  - MOVE(N_AXES-1) arrived → DONE.
  - DONE → IDLE after one cycle, pulsing `done`.
  - AUTO → IDLE when `s=0`.
- **Mode change mid-move**: `s` rising during MOVE aborts the move, with no `done` pulse. The FSM goes to AUTO via one cycle of all-00.
- `start` is ignored while `busy` or while `s=1`.

## Timing
- Reset values: `dir_out=0`, `busy=0`, `done=0`, `range_err=0`, state IDLE, all counters 0.
- `rst` mid-operation aborts immediately and forces all outputs to their reset values on the next edge.
- Latency: one cycle from inputs sampled at edge n to `dir_out` valid after edge n+1. `dir_out` is fully registered.
- `busy` rises in the cycle after the `start` edge and falls in the same cycle `done` pulses.
- Minimum move time with an axis already in band: `N_AXES*SETTLE_CYC + 2` cycles.
- Mode switch: `dir_out` is all-00 for exactly one cycle on any AUTO↔MOVE/IDLE transition.

## Structure
- Package `tracker_pkg` holds:
  - the direction constants `DIR_STOP`, `DIR_DEC`, `DIR_INC`;
  - the FSM state enum;
  - a modular-subtract function.
- Sub-module `wrap_dist` (one instance per axis): combinational. Inputs are target and actual. Outputs are `in_band` and the 2-bit direction. Parameters are `W`, `FULL_TURN` and `DEADBAND`.
- The top level contains the FSM, the axis index, the settle counters, the setpoint latch and the automatic-mode comparators with the reversal guard.

## Test plan
- Auto, axis 0 `a=100, b=200` → 01. Then `a=300, b=200` → 00 for one cycle, then 10. Then `a=202, b=200` → 00.
- Manual, `act=350, d=10`, `FULL_TURN=360` → axis 0 outputs 10 (wraps through 0). Hold in band for `SETTLE_CYC` cycles, then the FSM moves to axis 1.
- Manual, `act=0, d=180` → 10 (exact-half tie). With `d=181` → 01.
- `start` with `angle_d[1]=400` → `range_err=1`, `busy` stays 0, `dir_out=0`.
- Toggle `s` 0→1 mid MOVE(0) → one cycle of all-00, then automatic outputs, with no `done` pulse.
- Assert `rst` during MOVE(1) → next cycle `dir_out=0`, `busy=0`, state IDLE. `start` is accepted afterwards.
